raw10_depacker: RTL and testbench
=================================

# raw10_depacker

Converts the 4-lane MIPI CSI-2 RAW10 payload byte stream into 4 pixels per beat. Input is 32 bits per mipi byte clock, byte lane 0 first. RAW10 packs 4 pixels into 5 bytes, so 5 input words become 4 output words of 4×16-bit pixels. The block sits directly upstream of the debayer filter and drives its `line_valid_i`, `data_valid_i` and `data_i`.

## Interface
- `SHIFT`, default 0: left shift applied to each 10-bit pixel inside its 16-bit slot. Legal range 0..6; 6 gives MSB-justified output.
- `clk_i` in 1: mipi byte clock.
- `reset_i` in 1: reset, asynchronous, active-high.
- `line_valid_i` in 1: high for the whole payload of one line.
- `data_valid_i` in 1: `data_i` holds 4 valid payload bytes this cycle.
- `data_i` in 32: `[7:0]` is the earliest byte, `[31:24]` the latest.
- `line_valid_o` out 1: `line_valid_i` delayed 1 cycle.
- `output_valid_o` out 1: `output_o` holds 4 new pixels.
- `output_o` out 64: P0 (earliest) in `[63:48]`, P1 `[47:32]`, P2 `[31:16]`, P3 `[15:0]`.
- `partial_o` out 1: 1-cycle pulse when a line ends with bytes still unconsumed.

## Operation
- Group bytes b0..b4 map to pixels as Pi = {b_i, b4[2i+1:2i]}, for i = 0..3.
- Each pixel slot is `({6'b0, Pi} << SHIFT)` truncated to 16 bits.
- The phase counter `phase[2:0]` cycles 0→1→2→3→4→0. It advances only on cycles with `data_valid_i && line_valid_i`.
- The byte buffer holds at most 8 bytes; the unconsumed count is held in the buffer.
- Bytes held after each accepted word, by phase on entry:
  - phase 0: 4 held, no output.
  - phase 1: 8 held; emit using bytes 0-4; 3 remain.
  - phase 2: 7 held; emit; 2 remain.
  - phase 3: 6 held; emit; 1 remains.
  - phase 4: 5 held; emit; 0 remain.
- Net rate: 4 outputs per 5 accepted inputs.
- A `data_valid_i` gap holds phase and buffer unchanged. `output_valid_o` is 0 for that cycle.
- `data_valid_i` high while `line_valid_i` is low: the word is ignored.
- Falling edge of `line_valid_i` (seen as registered previous = 1, current = 0):
  - phase and buffer clear to 0.
  - `partial_o` = 1 for one cycle if phase ≠ 0. The leftover bytes are discarded.
- A rising edge of `line_valid_i` coinciding with valid data starts at phase 0 and accepts that word.
- Reset, including mid-line: all state clears immediately and no output is produced until the next accepted word.

## Timing
- Reset values:
  - `line_valid_o`, `output_valid_o`, `partial_o`: 0.
  - `output_o`: 64'h0.
  - `phase` and buffer: 0.
- Latency: `output_o` and `output_valid_o` are registered 1 cycle after the accepted word that completes a group.
- `line_valid_o` follows the same 1-cycle delay, so the line framing stays aligned with `output_valid_o`.
- `output_o` holds its last value while `output_valid_o` = 0.
- There is no backpressure. The downstream stage must accept every `output_valid_o` beat.
- Throughput: 1 input word per cycle sustained.
- Inputs are sampled on `posedge clk_i`. The line-end clear occurs on the cycle after `line_valid_i` is sampled low.

## Structure
- Shared package `csi_pkg`:
  - `RAW10_GROUP_BYTES` = 5.
  - `PIX_PER_BEAT` = 4.
  - `PIX_SLOT_W` = 16.
  - RAW10 data type code 8'h2B.
- Natural sub-module `raw10_unpack4`: purely combinational, 40 bits → 4×16 bits with `SHIFT`. Reused by a future 2-lane variant.
- Top level: phase counter, 64-bit byte buffer with byte-count muxing, line-edge detect, output registers.

## Test plan
- **Single group, `SHIFT`=0.** Words 0x00FF55AA, then 0x???? ??E4 with remaining bytes from the next group. Required output 1 cycle after the second word: `output_o` = 0x02A8_0155_03FE_0003, `output_valid_o` = 1.
- **Full line, 20 bytes/line × 2 lines.** Line of 5 consecutive words with a byte-counter pattern. Required:
  - exactly 4 `output_valid_o` pulses, on input words 2-5;
  - pixel values match the reference model;
  - no `partial_o`.
- **Gapped input.** Same line with `data_valid_i` low for 3 cycles between words 2 and 3. Required: identical outputs, delayed by 3 cycles; no spurious `output_valid_o`.
- **Short line, 3 words.** Required: 2 outputs, then a `partial_o` pulse after `line_valid_i` falls. The next line restarts at phase 0 with correct pixels.
- **`SHIFT`=6.** Pixel 0x3FF must produce slot 0xFFC0; pixel 0x001 must produce 0x0040.
- **Reset mid-group.** Assert `reset_i` after word 3 of a line. Required: all outputs 0 immediately. After release, a fresh line decodes correctly with no stale bytes.

Source files
------------

// File: rtl/csi_pkg.sv
// Shared CSI-2 receive constants and types.
package csi_pkg;

  localparam int RAW10_GROUP_BYTES = 5;
  localparam int PIX_PER_BEAT      = 4;
  localparam int PIX_SLOT_W        = 16;
  localparam logic [7:0] DT_RAW10  = 8'h2B;

  typedef enum logic [2:0] {
    PH0 = 3'd0,
    PH1 = 3'd1,
    PH2 = 3'd2,
    PH3 = 3'd3,
    PH4 = 3'd4
  } phase_e;

  function automatic phase_e phase_next(input phase_e ph);
    case (ph)
      PH0:     return PH1;
      PH1:     return PH2;
      PH2:     return PH3;
      PH3:     return PH4;
      default: return PH0;
    endcase
  endfunction

endpackage

// File: rtl/raw10_unpack4.sv
// Combinational RAW10 group unpack: 5 bytes -> 4 pixels, each left-shifted by SHIFT
// inside a 16-bit slot. P0 lands in the top slot.
module raw10_unpack4
  import csi_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  logic [8*RAW10_GROUP_BYTES-1:0]      group_i,
  output logic [PIX_PER_BEAT*PIX_SLOT_W-1:0]  pix_o
);

  localparam int LSB_BYTE = 8 * (RAW10_GROUP_BYTES - 1);

  for (genvar i = 0; i < PIX_PER_BEAT; i++) begin : g_pix
    logic [9:0]            pix;
    logic [PIX_SLOT_W-1:0] slot;

    assign pix  = {group_i[8*i +: 8], group_i[LSB_BYTE + 2*i +: 2]};
    assign slot = {6'b0, pix} << SHIFT;
    assign pix_o[PIX_SLOT_W*(PIX_PER_BEAT-1-i) +: PIX_SLOT_W] = slot;
  end

endmodule

// File: rtl/raw10_depacker.sv
// 4-lane CSI-2 RAW10 depacker: 5 accepted 32-bit words -> 4 beats of 4x16-bit pixels.
//   phase | meaning
//   PH0   | buffer empty; next word is buffered only
//   PH1   | 4 bytes held; next word completes a group, 3 left
//   PH2   | 3 bytes held; next word completes a group, 2 left
//   PH3   | 2 bytes held; next word completes a group, 1 left
//   PH4   | 1 byte held;  next word completes a group, 0 left
module raw10_depacker
  import csi_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        line_valid_i,
  input  logic        data_valid_i,
  input  logic [31:0] data_i,
  output logic        line_valid_o,
  output logic        output_valid_o,
  output logic [63:0] output_o,
  output logic        partial_o
);

  phase_e      phase_q;
  logic [63:0] buf_q;
  logic [2:0]  cnt_q;

  logic        accept;
  logic        line_fall;
  logic        line_rise;
  phase_e      phase_eff;
  logic [63:0] buf_eff;
  logic [2:0]  cnt_eff;
  logic [63:0] merged;
  logic [63:0] pix;

  // line_valid_o doubles as the registered previous line_valid_i for edge detect
  assign line_fall = line_valid_o && !line_valid_i;
  assign line_rise = !line_valid_o && line_valid_i;
  assign accept    = line_valid_i && data_valid_i;

  assign phase_eff = line_rise ? PH0   : phase_q;
  assign buf_eff   = line_rise ? '0    : buf_q;
  assign cnt_eff   = line_rise ? 3'd0  : cnt_q;

  // held bytes sit at the bottom with zeros above, so new bytes OR in at the fill point
  assign merged = buf_eff | ({32'b0, data_i} << {cnt_eff, 3'b000});

  raw10_unpack4 #(.SHIFT(SHIFT)) u_unpack (
    .group_i (merged[8*RAW10_GROUP_BYTES-1:0]),
    .pix_o   (pix)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      phase_q        <= PH0;
      buf_q          <= '0;
      cnt_q          <= '0;
      line_valid_o   <= 1'b0;
      output_valid_o <= 1'b0;
      output_o       <= '0;
      partial_o      <= 1'b0;
    end else begin
      line_valid_o   <= line_valid_i;
      output_valid_o <= 1'b0;
      partial_o      <= 1'b0;
      if (line_fall) begin
        phase_q   <= PH0;
        buf_q     <= '0;
        cnt_q     <= '0;
        partial_o <= (phase_q != PH0);
      end else if (accept) begin
        phase_q <= phase_next(phase_eff);
        if (phase_eff == PH0) begin
          buf_q <= merged;
          cnt_q <= 3'd4;
        end else begin
          buf_q          <= merged >> (8 * RAW10_GROUP_BYTES);
          cnt_q          <= cnt_eff - 3'd1;
          output_o       <= pix;
          output_valid_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_raw10_depacker.sv
// Bench for raw10_depacker: SHIFT=0 and SHIFT=6 instances on shared stimulus,
// checked against a byte-queue reference model.
module tb_raw10_depacker;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        line_valid_i;
  logic        data_valid_i;
  logic [31:0] data_i;

  logic        lv0, ov0, par0;
  logic [63:0] out0;
  logic        lv6, ov6, par6;
  logic [63:0] out6;

  int n_cmp = 0;
  int n_err = 0;
  int n_ov  = 0;

  logic [7:0]  q[$];
  bit          prev_lv;
  logic [63:0] last0, last6;

  always #5 clk_i = ~clk_i;

  raw10_depacker #(.SHIFT(0)) dut0 (
    .clk_i(clk_i), .reset_i(reset_i), .line_valid_i(line_valid_i),
    .data_valid_i(data_valid_i), .data_i(data_i), .line_valid_o(lv0),
    .output_valid_o(ov0), .output_o(out0), .partial_o(par0)
  );

  raw10_depacker #(.SHIFT(6)) dut6 (
    .clk_i(clk_i), .reset_i(reset_i), .line_valid_i(line_valid_i),
    .data_valid_i(data_valid_i), .data_i(data_i), .line_valid_o(lv6),
    .output_valid_o(ov6), .output_o(out6), .partial_o(par6)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", tag, $time, obs, exp);
    end
  endtask

  // Pixel i = byte i * 4 + its 2-bit fragment from byte 4, scaled by 2**sh, kept to 16 bits.
  function automatic logic [63:0] ref_pix(input logic [39:0] grp, input int sh);
    logic [63:0] r;
    int          v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      v = (int'(grp[8*i +: 8]) * 4 + int'(grp[32 + 2*i +: 2])) * (2 ** sh);
      r[16*(3-i) +: 16] = v[15:0];
    end
    return r;
  endfunction

  task automatic step(input bit lv, input bit dv, input logic [31:0] d);
    bit          ev, ep;
    logic [39:0] grp;
    line_valid_i = lv;
    data_valid_i = dv;
    data_i       = d;
    ev = 1'b0;
    ep = 1'b0;
    if (prev_lv && !lv) begin
      ep = (q.size() != 0);
      q.delete();
    end
    if (lv && dv) begin
      for (int b = 0; b < 4; b++) q.push_back(d[8*b +: 8]);
      if (q.size() >= 5) begin
        grp = {q[4], q[3], q[2], q[1], q[0]};
        repeat (5) void'(q.pop_front());
        last0 = ref_pix(grp, 0);
        last6 = ref_pix(grp, 6);
        ev    = 1'b1;
      end
    end
    prev_lv = lv;
    @(posedge clk_i);
    #1;
    if (ov0) n_ov++;
    chk("lv0",  64'(lv0),  64'(lv));
    chk("ov0",  64'(ov0),  64'(ev));
    chk("par0", 64'(par0), 64'(ep));
    chk("out0", out0, last0);
    chk("lv6",  64'(lv6),  64'(lv));
    chk("ov6",  64'(ov6),  64'(ev));
    chk("par6", 64'(par6), 64'(ep));
    chk("out6", out6, last6);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_lv"},  64'({lv0, lv6}),   64'd0);
    chk({tag, "_ov"},  64'({ov0, ov6}),   64'd0);
    chk({tag, "_par"}, 64'({par0, par6}), 64'd0);
    chk({tag, "_out0"}, out0, 64'd0);
    chk({tag, "_out6"}, out6, 64'd0);
  endtask

  task automatic do_reset();
    reset_i      = 1'b1;
    line_valid_i = 1'b0;
    data_valid_i = 1'b0;
    #1;
    q.delete();
    prev_lv = 1'b0;
    last0   = '0;
    last6   = '0;
    check_zero("reset");
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  task automatic counter_line(input int base, input int gap);
    for (int w = 0; w < 5; w++) begin
      step(1'b1, 1'b1, {8'(base + 4*w + 3), 8'(base + 4*w + 2), 8'(base + 4*w + 1), 8'(base + 4*w)});
      if (w == 1) repeat (gap) step(1'b1, 1'b0, $urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i      = 1'b1;
    line_valid_i = 1'b0;
    data_valid_i = 1'b0;
    data_i       = '0;
    prev_lv      = 1'b0;
    last0        = '0;
    last6        = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check_zero("init");
    reset_i = 1'b0;
    step(1'b0, 1'b0, 32'h0);

    // single group
    step(1'b1, 1'b1, 32'h00FF55AA);
    step(1'b1, 1'b1, 32'h332211E4);
    chk("single_out", out0, 64'h02A8_0155_03FE_0003);
    chk("single_ov",  64'(ov0), 64'd1);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    // two full counter lines, then the gapped line
    for (int l = 0; l < 2; l++) begin
      n_ov = 0;
      counter_line(20 * l, 0);
      step(1'b0, 1'b0, 32'h0);
      chk("full_pulses", 64'(n_ov), 64'd4);
      step(1'b0, 1'b0, 32'h0);
    end
    n_ov = 0;
    counter_line(0, 3);
    step(1'b0, 1'b0, 32'h0);
    chk("gap_pulses", 64'(n_ov), 64'd4);

    // short line: 2 beats, then partial
    n_ov = 0;
    for (int w = 0; w < 3; w++) step(1'b1, 1'b1, $urandom);
    step(1'b0, 1'b0, 32'h0);
    chk("short_pulses", 64'(n_ov), 64'd2);
    chk("short_partial", 64'(par0), 64'd1);
    counter_line(40, 0);
    step(1'b0, 1'b1, $urandom);

    // SHIFT=6 extremes: P0 = 0x3FF, P1 = 0x001
    step(1'b1, 1'b1, 32'h000000FF);
    step(1'b1, 1'b1, 32'hA5A5A507);
    chk("shift6_p0", 64'(out6[63:48]), 64'h0000_0000_0000_FFC0);
    chk("shift6_p1", 64'(out6[47:32]), 64'h0000_0000_0000_0040);
    step(1'b0, 1'b0, 32'h0);

    // reset mid-group, then a clean line
    for (int w = 0; w < 3; w++) step(1'b1, 1'b1, $urandom);
    do_reset();
    counter_line(100, 0);
    step(1'b0, 1'b0, 32'h0);

    // random lines with gaps and ignored out-of-line words
    for (int l = 0; l < 30; l++) begin
      int nw;
      nw = $urandom_range(1, 12);
      for (int w = 0; w < nw; w++) begin
        while ($urandom_range(0, 3) == 0) step(1'b1, 1'b0, $urandom);
        step(1'b1, 1'b1, $urandom);
      end
      repeat ($urandom_range(1, 3)) step(1'b0, 1'($urandom_range(0, 1)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
